// File: rtl/lcd_phase_tracker_pkg.sv
// lcd_pkg: state/phase codes, FSM state type and the state-to-phase fold shared by lcd_phase_tracker.
package lcd_pkg;
    localparam logic [3:0] ST_A1 = 4'b0000, ST_B = 4'b0001, ST_C = 4'b0010, ST_D = 4'b0011;
    localparam logic [3:0] ST_E1 = 4'b0100, ST_F = 4'b0101, ST_G = 4'b0110, ST_H = 4'b0111;
    localparam logic [3:0] ST_A2 = 4'b1000, ST_E2 = 4'b1100;
    localparam logic [3:0] PH_A = 4'd1, PH_B = 4'd2, PH_C = 4'd3, PH_D = 4'd4;
    localparam logic [3:0] PH_E = 4'd5, PH_F = 4'd6, PH_G = 4'd7, PH_H = 4'd8;

    typedef enum logic {S_IDLE, S_REQ} upd_state_t;

    function automatic logic [4:0] map_state(input logic [3:0] st);
        return !st[3]        ? {1'b1, {1'b0, st[2:0]} + 4'd1} :
               (st == ST_A2) ? {1'b1, PH_A} :
               (st == ST_E2) ? {1'b1, PH_E} : 5'b0;
    endfunction
endpackage

// File: rtl/lcd_phase_tracker_arbiter.sv
// lcd_rr_arbiter: picks the first requesting channel at or after i_ptr, wrapping N_CH-1 -> 0.
module lcd_rr_arbiter #(
    parameter int N_CH = 2,
    parameter int CH_W = 1
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [CH_W-1:0] i_ptr,
    output logic [N_CH-1:0] o_gnt,
    output logic [CH_W-1:0] o_idx,
    output logic            o_any
);
    assign o_any = |i_req;

    always_comb begin
        int j;
        j = 0;
        o_gnt = '0;
        o_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            j = (int'(i_ptr) + i) % N_CH;
            if (i_req[j]) begin
                o_gnt    = '0;
                o_gnt[j] = 1'b1;
                o_idx    = CH_W'(j);
            end
        end
    end
endmodule

// File: rtl/lcd_phase_tracker.sv
// lcd_phase_tracker: folds per-channel controller states into display phases and feeds changes to the LCD writer.
// Define LCD_DWELL_EN to add per-channel dwell counters on dwell_o.
module lcd_phase_tracker
    import lcd_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int PH_W      = 4,
    parameter int DWELL_W   = 16,
    parameter int RST_PHASE = 2,
    localparam int CH_W     = N_CH > 1 ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*4-1:0]       st_in,
    output logic [N_CH*PH_W-1:0]    phase_out,
    output logic [N_CH-1:0]         illegal_o,
    output logic                    upd_req,
    output logic [CH_W-1:0]         upd_ch,
    output logic [PH_W-1:0]         upd_phase,
`ifdef LCD_DWELL_EN
    output logic [N_CH*DWELL_W-1:0] dwell_o,
`endif
    input  logic                    upd_ack
);
    if (N_CH < 1 || N_CH > 16 || PH_W < 4 || DWELL_W < 1) begin : g_bad_cfg
        $error("lcd_phase_tracker: unsupported parameters");
    end

    logic [PH_W-1:0] r_phase [N_CH];
    logic [PH_W-1:0] w_new [N_CH];
    logic [N_CH-1:0] r_pend, r_illegal, w_chg, w_clr, w_legal, w_gnt;
    logic [CH_W-1:0] r_ptr, r_ch, w_gidx;
    logic [PH_W-1:0] r_uph, w_gph;
    logic            r_req, w_any, w_xfer;
    upd_state_t      r_state;

    assign w_xfer    = r_req & upd_ack;
    assign illegal_o = r_illegal;
    assign upd_req   = r_req;
    assign upd_ch    = r_ch;
    assign upd_phase = r_uph;

    genvar k;
    for (k = 0; k < N_CH; k++) begin : g_ch
        logic [4:0] w_map;
        assign w_map      = map_state(st_in[4*k +: 4]);
        assign w_legal[k] = w_map[4];
        assign w_new[k]   = PH_W'(w_map[3:0]);
        assign w_chg[k]   = w_legal[k] && (w_new[k] != r_phase[k]);
        // A phase that moved on while in flight keeps its pending bit so the newer value is resent.
        assign w_clr[k]   = w_xfer && (r_ch == CH_W'(k)) && (r_phase[k] == r_uph);
        assign phase_out[PH_W*k +: PH_W] = r_phase[k];
    end

    always_comb begin
        w_gph = '0;
        for (int i = 0; i < N_CH; i++) w_gph = w_gnt[i] ? r_phase[i] : w_gph;
    end

    lcd_rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
        .i_req(r_pend),
        .i_ptr(r_ptr),
        .o_gnt(w_gnt),
        .o_idx(w_gidx),
        .o_any(w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) r_phase[i] <= PH_W'(RST_PHASE);
            r_illegal <= '0;
            r_pend    <= '1;
            r_ptr     <= '0;
            r_ch      <= '0;
            r_uph     <= '0;
            r_req     <= 1'b0;
            r_state   <= S_IDLE;
        end else begin
            for (int i = 0; i < N_CH; i++) if (w_chg[i]) r_phase[i] <= w_new[i];
            r_illegal <= ~w_legal;
            r_pend    <= (r_pend & ~w_clr) | w_chg;
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                    r_ch    <= w_gidx;
                    r_uph   <= w_gph;
                    r_ptr   <= (w_gidx == CH_W'(N_CH - 1)) ? '0 : w_gidx + 1'b1;
                end
                S_REQ: if (upd_ack) begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LCD_DWELL_EN
    logic [DWELL_W-1:0] r_dwell [N_CH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++)
            r_dwell[i] <= (rst || w_chg[i]) ? '0 : r_dwell[i] + DWELL_W'(~&r_dwell[i]);
    end

    for (k = 0; k < N_CH; k++) begin : g_dwell
        assign dwell_o[DWELL_W*k +: DWELL_W] = r_dwell[k];
    end
`endif
endmodule

// File: tb/tb_lcd_phase_tracker.sv
// tb_lcd_phase_tracker: directed scenarios plus randomized traffic against a behavioural model of lcd_phase_tracker.
module tb_lcd_phase_tracker;
    localparam int N = 2, PHW = 4, DW = 4;

    logic             clk = 1'b0, rst = 1'b1, upd_ack = 1'b0;
    logic [4*N-1:0]   st_in = '0;
    logic [N*PHW-1:0] phase_out;
    logic [N-1:0]     illegal_o;
    logic             upd_req;
    logic [0:0]       upd_ch;
    logic [PHW-1:0]   upd_phase;
`ifdef LCD_DWELL_EN
    logic [N*DW-1:0]  dwell_o;
`endif

    lcd_phase_tracker #(.N_CH(N), .PH_W(PHW), .DWELL_W(DW), .RST_PHASE(2)) dut (
        .clk(clk), .rst(rst), .st_in(st_in), .phase_out(phase_out), .illegal_o(illegal_o),
        .upd_req(upd_req), .upd_ch(upd_ch), .upd_phase(upd_phase),
`ifdef LCD_DWELL_EN
        .dwell_o(dwell_o),
`endif
        .upd_ack(upd_ack)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int e_phase[N], e_dw[N], e_ch, e_uph, e_next;
    bit e_pend[N], e_ill[N], e_req;

    function automatic int ref_phase(input logic [3:0] s);
        if (s < 4'd8) return int'(s) + 1;
        if (s == 4'd8) return 1;
        if (s == 4'd12) return 5;
        return -1;
    endfunction

    // Drive one cycle and advance the model across the same clock edge.
    task automatic tick(input logic [4*N-1:0] st, input bit a, input bit r);
        bit xfer;
        int och, oph, g, p;
        rst = r; st_in = st; upd_ack = a;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < N; k++) begin
                e_phase[k] = 2; e_pend[k] = 1; e_ill[k] = 0; e_dw[k] = 0;
            end
            e_req = 0; e_ch = 0; e_uph = 0; e_next = 0;
        end else begin
            xfer = e_req && a; och = e_ch; oph = e_uph; g = -1;
            if (!e_req) begin
                for (int i = 0; i < N; i++)
                    if (g < 0 && e_pend[(e_next + i) % N]) g = (e_next + i) % N;
                if (g >= 0) begin
                    e_req = 1; e_ch = g; e_uph = e_phase[g]; e_next = (g + 1) % N;
                end
            end else if (xfer) e_req = 0;
            for (int k = 0; k < N; k++) begin
                p = ref_phase(st[4*k +: 4]);
                e_ill[k] = (p < 0);
                if (p >= 0 && p != e_phase[k]) begin
                    e_pend[k] = 1; e_phase[k] = p; e_dw[k] = 0;
                end else begin
                    if (xfer && och == k && oph == e_phase[k]) e_pend[k] = 0;
                    if (e_dw[k] < (1 << DW) - 1) e_dw[k]++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset;
        int got[$];
        tick(8'h11, 0, 1);
        tick(8'h11, 0, 1);
        checks++;
        if (phase_out !== 8'h22) begin failures++; $display("FAIL reset_phase: got %h expected 22", phase_out); end
        checks++;
        if ({upd_req, upd_ch, upd_phase, illegal_o} !== '0) begin
            failures++; $display("FAIL reset_upd: got req=%b ch=%0d ph=%0d ill=%b expected all 0", upd_req, upd_ch, upd_phase, illegal_o);
        end
        for (int c = 0; c < 6; c++) begin
            if (upd_req === 1'b1) got.push_back(int'(upd_ch) * 16 + int'(upd_phase));
            tick(8'h11, 1, 0);
        end
        checks++;
        if (got.size() != 2 || got[0] != 2 || got[1] != 18) begin
            failures++; $display("FAIL reset_resync: got %0d transfers %p expected ch0/ph2 then ch1/ph2", got.size(), got);
        end
    endtask

    task automatic test_map;
        logic [3:0] sv [3] = '{4'h0, 4'h1, 4'h8};
        int pv [3] = '{1, 2, 1};
        int got[$];
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < 4; c++) begin
                if (upd_req === 1'b1) got.push_back(int'(upd_ch) * 16 + int'(upd_phase));
                tick({4'h1, sv[s]}, 1, 0);
                if (c == 0) begin
                    checks++;
                    if (phase_out[3:0] !== 4'(pv[s])) begin
                        failures++; $display("FAIL map_st%h: got %0d expected %0d", sv[s], phase_out[3:0], pv[s]);
                    end
                end
            end
        end
        checks++;
        if (got.size() != 3 || got[0] != 1 || got[1] != 2 || got[2] != 1) begin
            failures++; $display("FAIL map_transfers: got %p expected ch0 phases 1,2,1", got);
        end
    endtask

    task automatic test_illegal;
        tick(8'h1A, 1, 0);
        checks++;
        if (illegal_o !== 2'b01 || phase_out !== 8'h21) begin
            failures++; $display("FAIL illegal_pulse: got ill=%b phase=%h expected ill=01 phase=21", illegal_o, phase_out);
        end
        for (int c = 0; c < 3; c++) begin
            tick(8'h18, 1, 0);
            checks++;
            if (upd_req !== 1'b0 || illegal_o !== 2'b00) begin
                failures++; $display("FAIL illegal_noupd: got req=%b ill=%b expected req=0 ill=00", upd_req, illegal_o);
            end
        end
    endtask

    task automatic test_stall;
        tick(8'h53, 0, 0);
        checks++;
        if (phase_out !== 8'h64) begin failures++; $display("FAIL stall_phase: got %h expected 64", phase_out); end
        for (int c = 0; c < 6; c++) begin
            tick(8'h53, 0, 0);
            checks++;
            if (upd_req !== 1'b1 || upd_ch !== 1'b1 || upd_phase !== 4'd6) begin
                failures++; $display("FAIL stall_hold%0d: got req=%b ch=%0d ph=%0d expected 1/1/6", c, upd_req, upd_ch, upd_phase);
            end
        end
        tick(8'h53, 1, 0);
        checks++;
        if (upd_req !== 1'b0) begin failures++; $display("FAIL stall_drop: got req=%b expected 0", upd_req); end
        tick(8'h53, 0, 0);
        checks++;
        if (upd_req !== 1'b1 || upd_ch !== 1'b0 || upd_phase !== 4'd4) begin
            failures++; $display("FAIL stall_next: got req=%b ch=%0d ph=%0d expected 1/0/4", upd_req, upd_ch, upd_phase);
        end
        for (int c = 0; c < 3; c++) tick(8'h53, 1, 0);
    endtask

    task automatic test_inflight;
        tick(8'h52, 0, 0);
        tick(8'h52, 0, 0);
        tick(8'h53, 0, 0);
        checks++;
        if (upd_req !== 1'b1 || upd_phase !== 4'd3 || phase_out[3:0] !== 4'd4) begin
            failures++; $display("FAIL inflight_hold: got req=%b ph=%0d phase0=%0d expected 1/3/4", upd_req, upd_phase, phase_out[3:0]);
        end
        tick(8'h53, 1, 0);
        tick(8'h53, 0, 0);
        checks++;
        if (upd_req !== 1'b1 || upd_ch !== 1'b0 || upd_phase !== 4'd4) begin
            failures++; $display("FAIL inflight_resend: got req=%b ch=%0d ph=%0d expected 1/0/4", upd_req, upd_ch, upd_phase);
        end
        tick(8'h53, 1, 0);
        tick(8'h53, 1, 0);
        checks++;
        if (upd_req !== 1'b0) begin failures++; $display("FAIL inflight_idle: got req=%b expected 0", upd_req); end
    endtask

    task automatic test_random;
        logic [4*N-1:0] st = 8'h53;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) if ($urandom_range(0, 3) == 0) st[4*k +: 4] = 4'($urandom_range(0, 15));
            tick(st, 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
            for (int k = 0; k < N; k++) begin
                checks++;
                if (phase_out[PHW*k +: PHW] !== 4'(e_phase[k]) || illegal_o[k] !== e_ill[k]) begin
                    failures++; $display("FAIL rand_ch%0d cyc%0d: got ph=%0d ill=%b expected ph=%0d ill=%b",
                        k, c, phase_out[PHW*k +: PHW], illegal_o[k], e_phase[k], e_ill[k]);
                end
`ifdef LCD_DWELL_EN
                checks++;
                if (dwell_o[DW*k +: DW] !== DW'(e_dw[k])) begin
                    failures++; $display("FAIL rand_dwell%0d cyc%0d: got %0d expected %0d", k, c, dwell_o[DW*k +: DW], e_dw[k]);
                end
`endif
            end
            checks++;
            if (upd_req !== e_req || upd_ch !== 1'(e_ch) || upd_phase !== 4'(e_uph)) begin
                failures++; $display("FAIL rand_upd cyc%0d: got req=%b ch=%0d ph=%0d expected req=%b ch=%0d ph=%0d",
                    c, upd_req, upd_ch, upd_phase, e_req, e_ch, e_uph);
            end
        end
    endtask

`ifdef LCD_DWELL_EN
    task automatic test_dwell;
        for (int c = 0; c < 20; c++) tick(8'h10, 1, 0);
        checks++;
        if (dwell_o[3:0] !== 4'hF) begin failures++; $display("FAIL dwell_sat: got %0d expected 15", dwell_o[3:0]); end
        tick(8'h11, 1, 0);
        checks++;
        if (dwell_o[3:0] !== 4'h0 || dwell_o[7:4] !== 4'hF) begin
            failures++; $display("FAIL dwell_clear: got ch0=%0d ch1=%0d expected 0/15", dwell_o[3:0], dwell_o[7:4]);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_map;
        test_illegal;
        test_stall;
        test_inflight;
        test_random;
`ifdef LCD_DWELL_EN
        test_dwell;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
